// File: rtl/demux_1_8_collector_v.sv
// Serial-to-parallel collector: one bit per handshake into slot sel, word out after 8 accepts (1-cycle latency).
// Only the 8th bit of a word stalls, and only while the previous word is still unread by the consumer.
module demux_1_8_collector_v #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    output logic       o_bit_ready,
    output logic [2:0] o_sel_code,
    output logic [7:0] o_code,
    output logic       o_code_valid,
    input  logic       i_code_ready
);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} ostate_t;

    logic [2:0] sel_q, sel_d;
    logic [7:0] asm_q, asm_d;
    logic [7:0] code_q, code_d;
    ostate_t    ostate_q, ostate_d;

    logic       acc;
    logic       last_slot;
    logic       complete;
    logic [2:0] slot;
    logic [7:0] asm_merged;

    assign last_slot    = (sel_q == 3'd7);
    assign o_bit_ready  = i_en & ~(last_slot & (ostate_q == HOLD) & ~i_code_ready);
    assign acc          = i_en & i_bit_valid & o_bit_ready;
    assign complete     = acc & last_slot;
    assign slot         = LSB_FIRST ? sel_q : (3'd7 - sel_q);

    always_comb begin
        asm_merged       = asm_q;
        asm_merged[slot] = i_bit;
    end

    always_comb begin
        sel_d    = sel_q;
        asm_d    = asm_q;
        code_d   = code_q;
        ostate_d = ostate_q;
        // Drain first; a same-cycle completion overrides it so no bubble appears.
        if (i_code_ready && ostate_q == HOLD) begin
            ostate_d = EMPTY;
        end
        if (acc) begin
            sel_d = sel_q + 3'd1;
            if (complete) begin
                code_d   = asm_merged;
                ostate_d = HOLD;
                asm_d    = 8'h00;
            end else begin
                asm_d = asm_merged;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel_q    <= 3'd0;
            asm_q    <= 8'h00;
            code_q   <= 8'h00;
            ostate_q <= EMPTY;
        end else begin
            sel_q    <= sel_d;
            asm_q    <= asm_d;
            code_q   <= code_d;
            ostate_q <= ostate_d;
        end
    end

    assign o_sel_code   = sel_q;
    assign o_code       = code_q;
    assign o_code_valid = (ostate_q == HOLD);

endmodule

// File: doc/demux_1_8_collector_v.md
# demux_1_8_collector_v

Serial-to-parallel counterpart of the 8:1 bit-select mux. It takes one bit per handshake on a serial input and steers each bit into the slot named by an internal 3-bit select code (the 1:8 demux direction). After 8 accepted bits it presents the assembled 8-bit code on a valid/ready output. It sits upstream of any consumer that reads an 8-bit code that was sourced bit-by-bit, for example by the 8:1 select mux walking its select code.

## Interface
- LSB_FIRST, default 1: 1 = first accepted bit lands in code[0]; 0 = first accepted bit lands in code[7].
- i_clk  input  1  single clock; all state updates on its rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_en  input  1  block enable; low = no bit accepted, all state held.
- i_bit  input  1  serial data bit.
- i_bit_valid  input  1  i_bit is valid this cycle.
- o_bit_ready  output  1  block can accept i_bit this cycle (combinational).
- o_sel_code  output  3  slot index the next accepted bit writes (registered).
- o_code  output  8  assembled code (registered).
- o_code_valid  output  1  o_code holds an unread word.
- i_code_ready  input  1  consumer takes o_code this cycle.

## Operation
- State:
  - slot counter sel[2:0];
  - assembly register asm[7:0];
  - output register o_code;
  - flag o_code_valid (output states EMPTY = 0, HOLD = 1).
- Bit accept: acc = i_en & i_bit_valid & o_bit_ready.
- Write target on acc:
  - LSB_FIRST = 1: asm[sel] <= i_bit.
  - LSB_FIRST = 0: asm[7-sel] <= i_bit.
- Counter on acc: sel <= sel+1, wrapping 7 -> 0.
- Word complete: acc with sel == 7.
  - o_code <= asm with the final bit merged in.
  - o_code_valid <= 1.
  - asm <= 0.
- o_bit_ready = i_en & ~(sel == 7 & o_code_valid & ~i_code_ready).
  - Only the 8th bit of a word stalls, and only while the previous word is still unread.
  - Bits 0-6 are always accepted while i_en is high.
- Output drain: i_code_ready & o_code_valid with no same-cycle completion -> o_code_valid <= 0; o_code keeps its value.
- Drain and completion in the same cycle: o_code_valid stays 1 and o_code updates to the new word (no bubble).
- i_code_ready while o_code_valid = 0: ignored.
- i_en low:
  - sel, asm, o_code and o_code_valid hold;
  - the output drain still operates.
- i_bit_valid low: nothing is written and sel holds.
- o_sel_code = sel.

## Timing
- Reset (i_rst high at an edge): sel = 0, asm = 0, o_code = 8'h00, o_code_valid = 0.
  - o_bit_ready follows i_en the cycle after reset.
- Reset mid-word discards the partial word; the next accepted bit goes to slot 0.
- Reset while o_code_valid = 1 drops the pending word.
- Reset has priority over every simultaneous event.
- Latency: 8th bit accepted at edge N -> o_code and o_code_valid visible after edge N, i.e. the consumer samples at edge N+1.
- Throughput: 1 bit/cycle sustained; one word every 8 cycles with i_code_ready held high.
- o_bit_ready depends combinationally on i_en, i_code_ready and state only; never on i_bit_valid.

## Test plan
- Continuous-stream check:
  - Stimulus: LSB_FIRST = 1, i_code_ready = 1; after reset, stream 1,0,1,1,0,0,1,0 on 8 consecutive cycles.
  - Response: o_code = 8'h4D with o_code_valid high for exactly 1 cycle, the cycle after the 8th accept; o_sel_code back to 0.
- Bit-order check: LSB_FIRST = 0 with the same stream -> o_code = 8'hB2.
- Backpressure check:
  - Stimulus: i_code_ready = 0; send word 8'hA5, then 7 bits of 8'h3C.
  - Required: all 7 bits are accepted; o_bit_ready = 0 at sel = 7; o_code holds 8'hA5.
  - Stimulus: raise i_code_ready.
  - Required: the 8th bit is accepted that same cycle; next cycle o_code = 8'h3C with o_code_valid still 1.
- Enable pause check:
  - Stimulus: i_en low for 5 cycles at sel = 3 while i_bit_valid = 1.
  - Required: o_sel_code stays 3 and nothing is accepted; after resuming, the word completes with the correct value (8'h96).
- Mid-word reset check:
  - Stimulus: i_rst for 1 cycle at sel = 5 with an earlier word pending.
  - Required: o_code_valid = 0, o_code = 8'h00, o_sel_code = 0; the next 8 bits form a clean word.
- Back-to-back check: words 8'hFF then 8'h00 streamed continuously with i_code_ready = 1 -> o_code_valid high in cycles 9 and 17 only.
